// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared sizing and pointer helper for the FIFO stream reader
package fifo_rd_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int SKID_DEPTH = 3;
    localparam int PTR_W = 2;
    localparam int OCC_W = 2;
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream carrying FIFO words downstream
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] data;
    logic valid;
    logic ready;
    modport master(output data, valid, input ready);
    modport slave(input data, valid, output ready);
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 3-entry circular buffer absorbing the FIFO read latency
module fifo_skid_buf import fifo_rd_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occ
);
    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] head, tail;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem  <= '{default: '0};
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) head <= next_ptr(head);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end
    assign head_data = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync FIFO into a valid/ready stream with credit-based reads
module fifo_stream_reader import fifo_rd_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  count_clr,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    fifo_stream_reader_if.master  m,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);
    logic infl;
    logic pop;
    logic [OCC_W-1:0] occ;
    assign fifo_rd_cs = en && rst;
    // a read is only issued when a buffer slot is reserved for it
    assign fifo_rd_en = fifo_rd_cs && !fifo_empty && ((3'(occ) + 3'(infl)) < 3'(SKID_DEPTH));
    assign m.valid    = occ != '0;
    assign pop        = m.valid && m.ready;
    assign busy       = infl || m.valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infl     <= 1'b0;
            rd_count <= '0;
        end else begin
            infl     <= fifo_rd_en;
            rd_count <= count_clr ? '0 : rd_count + CNT_WIDTH'(pop);
        end
    end
    fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (infl),
        .pop       (pop),
        .push_data (fifo_data),
        .head_data (m.data),
        .occ       (occ)
    );
endmodule
